spi_minion_stream_adapter: RTL

// - SPI mode-0 minion with val/rdy stream ports. It is the far end of the
//   FFT interconnect's SPI master port (master_cs/mosi/sclk/miso).
// - Also usable as a bench/peripheral minion for any team SPI master.
// - Each frame carries one write payload and one read payload, with a flow-control

---
 rtl/spi_minion_stream_adapter_if.sv | 28 ++
 rtl/spi_minion_stream_adapter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spi_minion_stream_adapter_if.sv
// Signal bundle between the SPI minion stream adapter and its surroundings:
// the SPI pins, the receive/send streams, and the status outputs.
interface spi_minion_stream_adapter_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 cs;
    logic                 sclk;
    logic                 mosi;
    logic                 miso;
    logic [BIT_WIDTH-1:0] recv_msg;
    logic                 recv_val;
    logic                 recv_rdy;
    logic [BIT_WIDTH-1:0] send_msg;
    logic                 send_val;
    logic                 send_rdy;
    logic                 frame_err;
    logic                 parity;

    modport slave (
        input  cs, sclk, mosi, recv_rdy, send_msg, send_val,
        output miso, recv_msg, recv_val, send_rdy, frame_err, parity
    );

    modport master (
        output cs, sclk, mosi, recv_rdy, send_msg, send_val,
        input  miso, recv_msg, recv_val, send_rdy, frame_err, parity
    );
endinterface

// File: rtl/spi_minion_stream_adapter.sv
// SPI mode-0 minion bridging frames to val/rdy streams with an rx FIFO and tx holding register.
// Optional feature: define SPI_MINION_PARITY_EN to drive parity = ^recv_msg while recv_val is high.
module spi_minion_stream_adapter #(
    parameter int BIT_WIDTH = 32,
    parameter int ENTRIES   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    spi_minion_stream_adapter_if.slave    bus
);
    localparam int FRAME_LEN = BIT_WIDTH + 2;
    localparam int CNT_W     = $clog2(BIT_WIDTH + 4);
    localparam int PTR_W     = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BIT_WIDTH + 3);
    localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    logic [1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
    logic       r_cs_prev, r_sclk_prev;
    logic       w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

    // Sync flops reset to 0 so a cs held low through reset is not taken as a new frame.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], bus.cs};
            r_sclk_sync <= {r_sclk_sync[0], bus.sclk};
            r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
            r_cs_prev   <= r_cs_sync[1];
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    assign w_cs_fall   =  r_cs_prev   & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_prev   &  r_cs_sync[1];
    assign w_sclk_rise = ~r_sclk_prev &  r_sclk_sync[1];
    assign w_sclk_fall =  r_sclk_prev & ~r_sclk_sync[1];

    state_t r_state, w_state_next;
    logic   w_frame_start, w_shift_in, w_shift_out, w_frame_ok, w_frame_bad;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_state_next = S_SHIFT;
            S_SHIFT: if (w_cs_rise) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    logic [CNT_W-1:0] r_bit_cnt;

    always_comb begin
        w_frame_start = 1'b0;
        w_shift_in    = 1'b0;
        w_shift_out   = 1'b0;
        w_frame_ok    = 1'b0;
        w_frame_bad   = 1'b0;
        if (r_state == S_IDLE) begin
            w_frame_start = w_cs_fall;
        end else begin
            w_shift_in  = w_sclk_rise;
            w_shift_out = w_sclk_fall;
            w_frame_ok  = w_cs_rise && (r_bit_cnt == CNT_FRAME);
            w_frame_bad = w_cs_rise && (r_bit_cnt != CNT_FRAME);
        end
    end

    logic [FRAME_LEN-1:0] r_mosi_sr, r_miso_sr;
    logic                 r_space_snap, r_valid_snap, r_tx_full, r_frame_err;
    logic [BIT_WIDTH-1:0] r_tx_reg;
    logic [PTR_W:0]       r_wr_ptr, r_rd_ptr;
    logic                 w_empty, w_full, w_push, w_pop, w_wr_flag, w_rd_flag;

    assign w_wr_flag = r_mosi_sr[FRAME_LEN-1];
    assign w_rd_flag = r_mosi_sr[FRAME_LEN-2];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push    = w_frame_ok && w_wr_flag && r_space_snap;
    assign w_pop     = !w_empty && bus.recv_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_mosi_sr    <= '0;
            r_miso_sr    <= '0;
            r_space_snap <= 1'b0;
            r_valid_snap <= 1'b0;
            r_tx_full    <= 1'b0;
            r_tx_reg     <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            if (w_frame_start) begin
                r_space_snap <= !w_full;
                r_valid_snap <= r_tx_full;
                r_miso_sr    <= {!w_full, r_tx_full, r_tx_full ? r_tx_reg : '0};
                r_bit_cnt    <= '0;
            end
            if (w_shift_in) begin
                r_mosi_sr <= {r_mosi_sr[FRAME_LEN-2:0], r_mosi_sync[1]};
                if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_shift_out) r_miso_sr <= r_miso_sr << 1;
            // Only a register reported valid at the cs fall may be consumed by this frame.
            if (w_frame_ok && w_rd_flag && r_valid_snap) begin
                r_tx_full <= 1'b0;
            end else if (bus.send_val && !r_tx_full) begin
                r_tx_full <= 1'b1;
                r_tx_reg  <= bus.send_msg;
            end
        end
    end

    logic [BIT_WIDTH-1:0] r_mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= r_mosi_sr[BIT_WIDTH-1:0];
    end

    assign bus.miso      = (r_state == S_SHIFT) && r_miso_sr[FRAME_LEN-1];
    assign bus.recv_val  = !w_empty;
    assign bus.recv_msg  = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
    assign bus.send_rdy  = !r_tx_full;
    assign bus.frame_err = r_frame_err;

`ifdef SPI_MINION_PARITY_EN
    assign bus.parity = !w_empty && (^r_mem[r_rd_ptr[PTR_W-1:0]]);
`else
    assign bus.parity = 1'b0;
`endif
endmodule
